// File: rtl/ppu_pkg.sv
// Shared types and sizing for the PPU background pipeline.
// Tile geometry and palette-index helpers used by the pixel shifter.
package ppu_pkg;

   localparam int unsigned TILE_W  = 8;
   localparam int unsigned FINEX_W = 3;
   localparam int unsigned PLANE_W = 2 * TILE_W;

   typedef logic [3:0] palette_index_t;

   // A zero colour index is transparent, so the attribute bits are dropped with it.
   function automatic palette_index_t make_index(input logic a1, input logic a0,
                                                 input logic p1, input logic p0);
      palette_index_t idx;
      idx = ({p1, p0} == 2'b00) ? palette_index_t'(0) : {a1, a0, p1, p0};
      return idx;
   endfunction

endpackage

// File: rtl/bg_plane_shifter.sv
// One background bit-plane: a 16-bit pattern shifter, an 8-bit attribute shifter fed by a
// one-bit attribute latch, and a fine-X tap on each.
module bg_plane_shifter
   import ppu_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clock_en_i,
   input  logic               shift_en_i,
   input  logic               reload_en_i,
   input  logic [TILE_W-1:0]  tile_byte_i,
   input  logic               attr_bit_i,
   input  logic [FINEX_W-1:0] fine_x_i,
   output logic               pat_bit_o,
   output logic               attr_bit_o
);

   logic [PLANE_W-1:0] pat_q, pat_d;
   logic [TILE_W-1:0]  attr_q, attr_d;
   logic               latch_q, latch_d;
   logic [PLANE_W-1:0] pat_tap;
   logic [TILE_W-1:0]  attr_tap;

   // Shift first, then a same-dot reload overwrites the low byte; the attribute plane
   // always takes the latch value from before this dot.
   always_comb begin
      pat_d   = pat_q;
      attr_d  = attr_q;
      latch_d = latch_q;
      if (clock_en_i) begin
         if (shift_en_i) begin
            pat_d  = {pat_q[PLANE_W-2:0], 1'b0};
            attr_d = {attr_q[TILE_W-2:0], latch_q};
         end
         if (reload_en_i) begin
            pat_d[TILE_W-1:0] = tile_byte_i;
            latch_d           = attr_bit_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pat_q   <= '0;
         attr_q  <= '0;
         latch_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         attr_q  <= attr_d;
         latch_q <= latch_d;
      end
   end

   // Fine-X selects counting from the MSB, taken from the pre-update state.
   assign pat_tap    = pat_q << fine_x_i;
   assign attr_tap   = attr_q << fine_x_i;
   assign pat_bit_o  = pat_tap[PLANE_W-1];
   assign attr_bit_o = attr_tap[TILE_W-1];

endmodule

// File: rtl/background_pixel_shifter.sv
// Background pixel shifter: two plane shifters plus PPUMASK masking and a registered
// 4-bit palette index for the sprite/background priority stage.
module background_pixel_shifter
   import ppu_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clock_EN,
   input  logic               shift_EN,
   input  logic               reload_EN,
   input  logic [TILE_W-1:0]  tileLowByte,
   input  logic [TILE_W-1:0]  tileHighByte,
   input  logic [1:0]         tileAttribute,
   input  logic [FINEX_W-1:0] fineX_IN,
   input  logic               showBackground,
   input  logic               showLeft8,
   input  logic [7:0]         pixelX,
   input  logic               pixelActive,
   output logic [3:0]         bgPixel_OUT,
   output logic               bgPixelValid_OUT
);

   logic           p0, p1, a0, a1;
   logic           masked;
   palette_index_t pix_q, pix_d;
   logic           valid_q, valid_d;

   bg_plane_shifter u_plane0 (
      .clk_i       (clock),
      .rst_i       (reset),
      .clock_en_i  (clock_EN),
      .shift_en_i  (shift_EN),
      .reload_en_i (reload_EN),
      .tile_byte_i (tileLowByte),
      .attr_bit_i  (tileAttribute[0]),
      .fine_x_i    (fineX_IN),
      .pat_bit_o   (p0),
      .attr_bit_o  (a0)
   );

   bg_plane_shifter u_plane1 (
      .clk_i       (clock),
      .rst_i       (reset),
      .clock_en_i  (clock_EN),
      .shift_en_i  (shift_EN),
      .reload_en_i (reload_EN),
      .tile_byte_i (tileHighByte),
      .attr_bit_i  (tileAttribute[1]),
      .fine_x_i    (fineX_IN),
      .pat_bit_o   (p1),
      .attr_bit_o  (a1)
   );

   always_comb begin
      masked  = !showBackground || ((pixelX < 8'(TILE_W)) && !showLeft8) || !pixelActive;
      pix_d   = pix_q;
      valid_d = valid_q;
      if (clock_EN) begin
         pix_d   = masked ? palette_index_t'(0) : make_index(a1, a0, p1, p0);
         valid_d = pixelActive;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pix_q   <= pix_d;
         valid_q <= valid_d;
      end
   end

   assign bgPixel_OUT      = pix_q;
   assign bgPixelValid_OUT = valid_q;

endmodule

// File: tb/tb_background_pixel_shifter.sv
// Self-checking bench for background_pixel_shifter: directed scenarios plus random dots,
// all compared against an arithmetic model of the planes and output register.
module tb_background_pixel_shifter;

   logic       clock;
   logic       reset;
   logic       clock_EN;
   logic       shift_EN;
   logic       reload_EN;
   logic [7:0] tileLowByte;
   logic [7:0] tileHighByte;
   logic [1:0] tileAttribute;
   logic [2:0] fineX_IN;
   logic       showBackground;
   logic       showLeft8;
   logic [7:0] pixelX;
   logic       pixelActive;
   logic [3:0] bgPixel_OUT;
   logic       bgPixelValid_OUT;

   int errors = 0;
   int checks = 0;

   // Model state: planes as plain integers, index 0 = low/attr[0], 1 = high/attr[1].
   int unsigned m_pat[2];
   int unsigned m_attr[2];
   int unsigned m_latch[2];
   logic [3:0]  m_pix;
   logic        m_valid;

   background_pixel_shifter dut (
      .clock            (clock),
      .reset            (reset),
      .clock_EN         (clock_EN),
      .shift_EN         (shift_EN),
      .reload_EN        (reload_EN),
      .tileLowByte      (tileLowByte),
      .tileHighByte     (tileHighByte),
      .tileAttribute    (tileAttribute),
      .fineX_IN         (fineX_IN),
      .showBackground   (showBackground),
      .showLeft8        (showLeft8),
      .pixelX           (pixelX),
      .pixelActive      (pixelActive),
      .bgPixel_OUT      (bgPixel_OUT),
      .bgPixelValid_OUT (bgPixelValid_OUT)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_pat[k]   = 0;
         m_attr[k]  = 0;
         m_latch[k] = 0;
      end
      m_pix   = 4'h0;
      m_valid = 1'b0;
   endtask

   // Drive one dot, advance the model, and return #1 after the clock edge.
   task automatic dot(input bit ce, input bit sh, input bit rl, input int lo, input int hi,
                      input int at, input int fx, input bit sbg, input bit sl8, input int px,
                      input bit act);
      int  p[2];
      int  a[2];
      bit  masked;
      clock_EN       = ce;
      shift_EN       = sh;
      reload_EN      = rl;
      tileLowByte    = 8'(lo);
      tileHighByte   = 8'(hi);
      tileAttribute  = 2'(at);
      fineX_IN       = 3'(fx);
      showBackground = sbg;
      showLeft8      = sl8;
      pixelX         = 8'(px);
      pixelActive    = act;
      if (ce) begin
         for (int k = 0; k < 2; k++) begin
            p[k] = int'((m_pat[k] >> (15 - fx)) % 2);
            a[k] = int'((m_attr[k] >> (7 - fx)) % 2);
         end
         masked = !sbg || (px < 8 && !sl8) || !act;
         if (masked || (p[0] == 0 && p[1] == 0)) m_pix = 4'h0;
         else m_pix = 4'(a[1] * 8 + a[0] * 4 + p[1] * 2 + p[0]);
         m_valid = act;
         if (sh) begin
            for (int k = 0; k < 2; k++) begin
               m_pat[k]  = (m_pat[k] * 2) % 65536;
               m_attr[k] = (m_attr[k] * 2) % 256 + m_latch[k];
            end
         end
         if (rl) begin
            m_pat[0]   = m_pat[0] - m_pat[0] % 256 + int'(lo);
            m_pat[1]   = m_pat[1] - m_pat[1] % 256 + int'(hi);
            m_latch[0] = at % 2;
            m_latch[1] = at / 2;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (bgPixel_OUT !== 4'h0 || bgPixelValid_OUT !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial got %h/%b want 0/0", bgPixel_OUT, bgPixelValid_OUT);
      end
      reset = 1'b0;
      model_clear();
      dot(1, 0, 1, 'hFF, 'hFF, 3, 0, 1, 1, 20, 0);
      for (int i = 0; i < 10; i++) dot(1, 1, (i == 7), 'hFF, 'hFF, 3, 0, 1, 1, 20 + i, 1);
      checks++;
      if (bgPixel_OUT !== m_pix || m_pix === 4'h0) begin
         errors++;
         $display("FAIL reset_prefill got %h want %h (nonzero)", bgPixel_OUT, m_pix);
      end
      // Assert mid-cycle, away from any clock edge.
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bgPixel_OUT !== 4'h0 || bgPixelValid_OUT !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got %h/%b want 0/0", bgPixel_OUT, bgPixelValid_OUT);
      end
      #3 reset = 1'b0;
      model_clear();
      @(posedge clock);
      #1;
      for (int fx = 0; fx < 8; fx++) begin
         dot(1, 0, 0, 0, 0, 0, fx, 1, 1, 100, 1);
         checks++;
         if (bgPixel_OUT !== 4'h0 || bgPixelValid_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_planes fx=%0d got %h/%b want 0/1", fx, bgPixel_OUT,
                     bgPixelValid_OUT);
         end
      end
   endtask

   task automatic test_alternate();
      logic [3:0] want;
      dot(1, 0, 1, 'hAA, 'h00, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) dot(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      dot(1, 0, 1, 'h00, 'h00, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         dot(1, 1, 0, 0, 0, 0, 0, 1, 1, 8 + i, 1);
         want = (i % 2 == 0) ? 4'h5 : 4'h0;
         checks++;
         if (bgPixel_OUT !== want || bgPixel_OUT !== m_pix || bgPixelValid_OUT !== 1'b1) begin
            errors++;
            $display("FAIL alternate i=%0d got %h want %h", i, bgPixel_OUT, want);
         end
      end
   endtask

   task automatic test_finex();
      logic [3:0] want;
      dot(1, 0, 1, 'hAA, 'h00, 1, 3, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) dot(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      dot(1, 0, 1, 'hFF, 'h0F, 2, 3, 1, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         dot(1, 1, (i == 7), 'h5C, 'hE3, 3, 3, 1, 1, 16 + i, 1);
         want = m_pix;
         if (i < 4) want = (i % 2 == 0) ? 4'h0 : 4'h5;
         checks++;
         if (bgPixel_OUT !== m_pix || bgPixel_OUT !== want) begin
            errors++;
            $display("FAIL finex3 i=%0d got %h want %h", i, bgPixel_OUT, m_pix);
         end
      end
   endtask

   task automatic test_shift_reload();
      dot(1, 0, 1, 'h01, 'h00, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 15; i++) dot(1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      dot(1, 1, 1, 'hFF, 'h00, 2, 0, 1, 1, 50, 1);
      checks++;
      if (bgPixel_OUT !== 4'h5 || m_pat[0] != 'h00FF) begin
         errors++;
         $display("FAIL shift_reload_dot got %h want 5", bgPixel_OUT);
      end
      for (int i = 0; i < 16; i++) begin
         dot(1, 1, 0, 0, 0, 0, i % 8, 1, 1, 51 + i, 1);
         checks++;
         if (bgPixel_OUT !== m_pix) begin
            errors++;
            $display("FAIL shift_reload_seq i=%0d got %h want %h", i, bgPixel_OUT, m_pix);
         end
      end
      // Rebuild: after 8 shifts past the combined dot, low byte sits on top with new latch.
      dot(1, 0, 1, 'h01, 'h00, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 15; i++) dot(1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      dot(1, 1, 1, 'hFF, 'h00, 2, 0, 1, 1, 50, 0);
      for (int i = 0; i < 8; i++) dot(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      dot(1, 0, 0, 0, 0, 0, 0, 1, 1, 60, 1);
      checks++;
      if (bgPixel_OUT !== 4'h9) begin
         errors++;
         $display("FAIL shift_reload_latch got %h want 9", bgPixel_OUT);
      end
   endtask

   task automatic test_masking();
      logic [3:0] want;
      dot(1, 0, 1, 'hFF, 'hFF, 3, 0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) dot(1, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0);
      for (int px = 0; px <= 8; px++) begin
         dot(1, 0, 0, 0, 0, 0, px % 8, 1, 0, px, 1);
         want = (px < 8) ? 4'h0 : 4'hF;
         checks++;
         if (bgPixel_OUT !== want || bgPixelValid_OUT !== 1'b1) begin
            errors++;
            $display("FAIL left8 px=%0d got %h/%b want %h/1", px, bgPixel_OUT, bgPixelValid_OUT,
                     want);
         end
      end
      for (int i = 0; i < 4; i++) begin
         dot(1, (i >= 2), 0, 0, 0, 0, 0, 0, 1, 100 + i, (i != 1));
         checks++;
         if (bgPixel_OUT !== 4'h0 || bgPixelValid_OUT !== (i != 1)) begin
            errors++;
            $display("FAIL bg_off i=%0d got %h/%b want 0/%0d", i, bgPixel_OUT,
                     bgPixelValid_OUT, (i != 1));
         end
      end
      dot(1, 0, 0, 0, 0, 0, 0, 1, 1, 100, 1);
      checks++;
      if (bgPixel_OUT !== m_pix || bgPixel_OUT !== 4'hF) begin
         errors++;
         $display("FAIL bg_off_shifted got %h want F", bgPixel_OUT);
      end
   endtask

   task automatic test_clock_enable();
      logic [3:0] held_pix;
      logic       held_valid;
      dot(1, 0, 1, 'h96, 'h3C, 2, 0, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) dot(1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      dot(1, 0, 1, 'h69, 'hC3, 1, 0, 1, 1, 0, 0);
      dot(1, 1, 0, 0, 0, 0, 0, 1, 1, 30, 1);
      held_pix   = m_pix;
      held_valid = m_valid;
      for (int i = 0; i < 3; i++) begin
         dot(0, 1, 1, 'hFF, 'hFF, 3, i, 1, 1, 31, i % 2);
         checks++;
         if (bgPixel_OUT !== held_pix || bgPixelValid_OUT !== held_valid) begin
            errors++;
            $display("FAIL clock_en_hold i=%0d got %h/%b want %h/%b", i, bgPixel_OUT,
                     bgPixelValid_OUT, held_pix, held_valid);
         end
      end
      for (int i = 0; i < 12; i++) begin
         dot(1, 1, (i == 6), 'h0F, 'hF0, 3, 0, 1, 1, 31 + i, 1);
         checks++;
         if (bgPixel_OUT !== m_pix || bgPixelValid_OUT !== m_valid) begin
            errors++;
            $display("FAIL clock_en_resume i=%0d got %h want %h", i, bgPixel_OUT, m_pix);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         dot(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(5) == 0),
             int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(3)),
             int'($urandom_range(7)), ($urandom_range(7) != 0), $urandom_range(1),
             int'($urandom_range(255)), ($urandom_range(5) != 0));
         checks++;
         if (bgPixel_OUT !== m_pix || bgPixelValid_OUT !== m_valid) begin
            errors++;
            $display("FAIL random i=%0d got %h/%b want %h/%b", i, bgPixel_OUT,
                     bgPixelValid_OUT, m_pix, m_valid);
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      clock_EN       = 1'b0;
      shift_EN       = 1'b0;
      reload_EN      = 1'b0;
      tileLowByte    = 8'h00;
      tileHighByte   = 8'h00;
      tileAttribute  = 2'b00;
      fineX_IN       = 3'd0;
      showBackground = 1'b0;
      showLeft8      = 1'b0;
      pixelX         = 8'd0;
      pixelActive    = 1'b0;
      #12;
      test_reset();
      test_alternate();
      test_finex();
      test_shift_reload();
      test_masking();
      test_clock_enable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
